// File: rtl/traffic_pkg.sv
// Shared light encodings, FSM state set and per-state duration lookup
// for the two-group intersection controller.
package traffic_pkg;

  localparam logic [3:0] C_RED    = 4'b1000;
  localparam logic [3:0] C_YELLOW = 4'b0100;
  localparam logic [3:0] C_LEFT   = 4'b0010;
  localparam logic [3:0] C_GREEN  = 4'b0001;
  localparam logic [3:0] C_NONE   = 4'b0000;

  localparam logic [1:0] W_RED    = 2'b10;
  localparam logic [1:0] W_GREEN  = 2'b01;
  localparam logic [1:0] W_NONE   = 2'b00;

  typedef enum logic [3:0] {
    A_GREEN  = 4'd0,
    A_YEL1   = 4'd1,
    A_LEFT   = 4'd2,
    A_YEL2   = 4'd3,
    A_ALLRED = 4'd4,
    B_GREEN  = 4'd5,
    B_YEL1   = 4'd6,
    B_LEFT   = 4'd7,
    B_YEL2   = 4'd8,
    B_ALLRED = 4'd9,
    NIGHT    = 4'd10
  } state_e;

  // NIGHT has no timed length; it reuses the green length so the timer holds a sane value.
  function automatic int state_dur(input state_e s, input int t_green, input int t_yellow,
                                   input int t_left, input int t_allred);
    case (s)
      A_GREEN, B_GREEN:               state_dur = t_green;
      A_YEL1, A_YEL2, B_YEL1, B_YEL2: state_dur = t_yellow;
      A_LEFT, B_LEFT:                 state_dur = t_left;
      A_ALLRED, B_ALLRED:             state_dur = t_allred;
      default:                        state_dur = t_green;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_tick_timer.sv
// Loadable down-counter advanced by a tick enable; saturates at zero and flags it.
module tick_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// Two-group intersection controller: timed car phases, all-red clearance,
// latched pedestrian calls served in the opposite group's green, night flashing.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR    = 4,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 2,
  parameter int T_LEFT   = 10,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 14,
  parameter int T_FLASH  = 6,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_tick,
  input  logic               i_night,
  input  logic [N_DIR-1:0]   i_ped_req,
  output logic [4*N_DIR-1:0] o_car,
  output logic [2*N_DIR-1:0] o_walker,
  output logic [3:0]         o_state,
  output logic [1:0]         o_ped_served
);

  localparam logic [N_DIR-1:0] MASK_A = {(N_DIR/2){2'b01}};

  state_e           r_state, w_next;
  logic [1:0]       r_ped_pend, w_pend_next;
  logic [1:0]       r_walk, w_walk_next;
  logic [1:0]       r_served, w_served_next;
  logic             r_night_tog, w_tog_next;
  logic             w_step, w_zero, w_load;
  logic [CNT_W-1:0] w_cnt, w_load_val, w_elapsed;
  logic [1:0]       w_req_grp;
  logic [3:0]       w_car_a, w_car_b;
  logic [1:0]       w_walk_a, w_walk_b;
  logic             w_on;

  assign w_step     = i_start & i_tick;
  assign w_req_grp  = {|(i_ped_req & ~MASK_A), |(i_ped_req & MASK_A)};
  assign w_load     = (w_next != r_state);
  assign w_load_val = CNT_W'(state_dur(w_next, T_GREEN, T_YELLOW, T_LEFT, T_ALLRED) - 1);
  assign w_elapsed  = CNT_W'(T_GREEN - 1) - w_cnt;

  tick_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_GREEN - 1))
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_step && (r_state != NIGHT)),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= A_GREEN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_step) begin
      if (r_state == NIGHT) begin
        if (!i_night) w_next = A_GREEN;
      end else if (w_zero) begin
        case (r_state)
          A_GREEN:  w_next = A_YEL1;
          A_YEL1:   w_next = A_LEFT;
          A_LEFT:   w_next = A_YEL2;
          A_YEL2:   w_next = A_ALLRED;
          A_ALLRED: w_next = B_GREEN;
          B_GREEN:  w_next = B_YEL1;
          B_YEL1:   w_next = B_LEFT;
          B_LEFT:   w_next = B_YEL2;
          B_YEL2:   w_next = B_ALLRED;
          B_ALLRED: w_next = i_night ? NIGHT : A_GREEN;
          default:  w_next = A_GREEN;
        endcase
      end
    end
  end

  // Entering a group's green serves the other group's walkers; the clear beats a same-cycle request.
  always_comb begin
    w_pend_next   = r_ped_pend;
    w_walk_next   = r_walk;
    w_served_next = '0;
    w_tog_next    = r_night_tog;
    if (i_start) w_pend_next = r_ped_pend | w_req_grp;
    if ((w_next == B_GREEN) && (r_state != B_GREEN)) begin
      w_served_next[0] = w_pend_next[0];
      w_walk_next[0]   = w_pend_next[0];
      w_pend_next[0]   = 1'b0;
    end
    if ((w_next == A_GREEN) && (r_state != A_GREEN)) begin
      w_served_next[1] = w_pend_next[1];
      w_walk_next[1]   = w_pend_next[1];
      w_pend_next[1]   = 1'b0;
    end
    if ((r_state == NIGHT) && w_step) w_tog_next = ~r_night_tog;
    if ((w_next == NIGHT) && (r_state != NIGHT)) w_tog_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ped_pend  <= '0;
      r_walk      <= '0;
      r_served    <= '0;
      r_night_tog <= 1'b0;
    end else begin
      r_ped_pend  <= w_pend_next;
      r_walk      <= w_walk_next;
      r_served    <= w_served_next;
      r_night_tog <= w_tog_next;
    end
  end

  function automatic logic [1:0] walk_color(input logic armed, input logic in_green,
                                            input logic [CNT_W-1:0] el);
    if (!armed || !in_green)            walk_color = W_RED;
    else if (el < CNT_W'(T_WALK))       walk_color = W_GREEN;
    else if (el < CNT_W'(T_WALK + T_FLASH)) walk_color = el[0] ? W_NONE : W_GREEN;
    else                                walk_color = W_RED;
  endfunction

  always_comb begin
    w_car_a  = C_RED;
    w_car_b  = C_RED;
    w_walk_a = walk_color(r_walk[0], r_state == B_GREEN, w_elapsed);
    w_walk_b = walk_color(r_walk[1], r_state == A_GREEN, w_elapsed);
    case (r_state)
      A_GREEN:        w_car_a = C_GREEN;
      A_YEL1, A_YEL2: w_car_a = C_YELLOW;
      A_LEFT:         w_car_a = C_LEFT;
      B_GREEN:        w_car_b = C_GREEN;
      B_YEL1, B_YEL2: w_car_b = C_YELLOW;
      B_LEFT:         w_car_b = C_LEFT;
      NIGHT: begin
        w_car_a  = r_night_tog ? C_NONE : C_YELLOW;
        w_car_b  = r_night_tog ? C_NONE : C_YELLOW;
        w_walk_a = W_NONE;
        w_walk_b = W_NONE;
      end
      default: ;
    endcase
  end

  assign w_on         = i_start & reset_n;
  assign o_car        = w_on ? {(N_DIR/2){w_car_b, w_car_a}} : '0;
  assign o_walker     = w_on ? {(N_DIR/2){w_walk_b, w_walk_a}} : '0;
  assign o_state      = r_state;
  assign o_ped_served = r_served;

endmodule
